ofdm_cp_insert: RTL and testbench
=================================

// Module: ofdm_cp_insert
// PURPOSE
//  Cyclic-prefix insertion stage of the OFDM TX chain; sits directly after the IFFT.
//  Consumes IFFT output symbols (NFFT complex samples, natural order) over AXI-Stream.
//  Emits CP_LEN tail samples followed by the full NFFT-sample symbol.
//  Ping-pong buffering lets one symbol be written while the previous one is read out.
// PARAMETERS
//  NFFT    64  samples per OFDM symbol; power of 2, >= 8
//  CP_LEN  16  cyclic-prefix length in samples; 1 <= CP_LEN < NFFT
//  DW      32  sample width, {I[31:16], Q[15:0]}, two's complement; passed through untouched
// PORTS
//  clk              in   1    system clock
//  rst_n            in   1    asynchronous, active-low reset
//  s_axis_tdata     in   DW   IFFT output sample
//  s_axis_tvalid    in   1    input sample valid
//  s_axis_tready    out  1    input accept
//  s_axis_tlast     in   1    IFFT end-of-symbol marker; checked only, never trusted for framing
//  m_axis_tdata     out  DW   output sample (CP, then body)
//  m_axis_tvalid    out  1    output sample valid
//  m_axis_tready    in   1    downstream accept
//  m_axis_tlast     out  1    last (NFFT+CP_LEN-th) sample of the output symbol
//  m_axis_tuser     out  1    first sample of the output symbol (first CP sample)
//  event_tlast_err  out  1    1-cycle pulse: tlast missing at index NFFT-1 or present elsewhere
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, wr_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=0, FSM=IDLE.
//  Reset mid-operation discards both banks; no partial symbol is ever emitted after release.
//  Write side:
//  - s_axis_tready = !full[wr_bank], from registered state only.
//  - On handshake: mem[wr_bank][wr_cnt] <= tdata.
//  - wr_cnt increments, wraps NFFT-1 -> 0.
//  - At wr_cnt==NFFT-1: set full[wr_bank], toggle wr_bank.
//  - Framing uses wr_cnt only.
//  - event_tlast_err pulses in the cycle after a handshake where (tlast != (wr_cnt==NFFT-1)).
//  Read FSM: IDLE -> CP -> BODY -> (CP if full[!rd_bank] else IDLE).
//  - IDLE: when full[rd_bank], go to CP with rd_idx=NFFT-CP_LEN.
//  - CP: reads rd_idx NFFT-CP_LEN..NFFT-1, then BODY with rd_idx=0.
//  - BODY: reads 0..NFFT-1.
//  - On the read of index NFFT-1 in BODY: clear full[rd_bank], toggle rd_bank.
//  - CP->BODY and BODY->CP transitions are bubble-free.
//  Output register:
//  - One register stage, loaded only when (!m_axis_tvalid || m_axis_tready).
//  - tdata/tlast/tuser hold stable while tvalid && !tready.
//  - FSM advances only on a load.
//  Latency: last input handshake in cycle N -> first CP sample valid (tuser=1) in cycle N+2.
//  Throughput: 1 sample/cycle out.
//  - Input is back-pressured (NFFT in per NFFT+CP_LEN out) once both banks are full.
//  - Continuous input plus tready=1 gives gapless output.
//  Simultaneous events:
//  - Reader freeing bank B and writer filling bank !B in the same cycle are independent flag bits.
//  - A freed bank becomes writable the next cycle (tready is registered-state based).
//  Width: addresses $clog2(NFFT); counters never exceed NFFT-1. No arithmetic on sample data.
// STRUCTURE
//  ofdm_pkg (shared):
//  - NFFT_DEF, CP_LEN_DEF.
//  - typedef cplx_t = struct packed {logic signed [15:0] i, q;}.
//  - enum cp_state_t {IDLE, CP, BODY}.
//  Sub-module ofdm_cp_pingpong_ram:
//  - 2*NFFT x DW, 1 sync write port, 1 async read port.
//  - Address = {bank, idx}; maps to distributed RAM.
//  Top holds write counter, read FSM, full flags, output register.
// TESTING
//  1. Single ramp symbol 0..63, tlast on 63, m_tready=1:
//     - Output 80 samples: 48..63 then 0..63.
//     - tuser on sample 0, tlast on sample 79, event_tlast_err never set.
//  2. Four back-to-back symbols (base k*256+idx), m_tready=1:
//     - 320 output samples, no gap after the first.
//     - s_axis_tready drops whenever both banks are full.
//  3. m_axis_tready random at 50%:
//     - Same sequence as case 2.
//     - tdata/tlast/tuser never change while tvalid && !tready.
//  4. tlast at index 40, and tlast absent at 63:
//     - event_tlast_err pulses once for each.
//     - Symbol still 64 samples; output identical to case 1.
//  5. rst_n low during CP of symbol 2:
//     - All outputs 0 immediately.
//     - After release, a fresh ramp symbol outputs exactly as case 1, with no residual samples.
//  6. Parameter sweep NFFT=16, CP_LEN=4: output 12..15, 0..15; tlast on sample 19.

Source files
------------

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared types and defaults for the OFDM cyclic-prefix stage
package ofdm_pkg;

  localparam int NFFT_DEF   = 64;
  localparam int CP_LEN_DEF = 16;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, CP, BODY} cp_state_t;

endpackage

// File: rtl/ofdm_cp_pingpong_ram.sv
// rtl/ofdm_cp_pingpong_ram.sv - two-bank symbol buffer, sync write, async read
module ofdm_cp_pingpong_ram #(
  parameter int NFFT = 64,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(NFFT):0]    waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NFFT):0]    raddr,
  output logic [DW-1:0]            rdata
);

  // Address is {bank, idx}; no reset so it maps onto distributed RAM.
  logic [DW-1:0] mem [2*NFFT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ofdm_cp_insert.sv
// rtl/ofdm_cp_insert.sv - cyclic-prefix insertion with ping-pong symbol buffering
module ofdm_cp_insert
  import ofdm_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  output logic          event_tlast_err
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_START = AW'(NFFT - CP_LEN);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_idx_q, rd_idx_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          rdy_q, rdy_d;
  cp_state_t     state_q, state_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic          err_q, err_d;

  logic          wr_en, load, rd_act;
  cp_state_t     cur_state;
  logic [AW-1:0] cur_idx;
  logic [DW-1:0] rd_data;

  // rdy_q keeps tready low while in reset and for the first cycle after release.
  assign s_axis_tready   = rdy_q && !full_q[wr_bank_q];
  assign wr_en           = s_axis_tvalid && s_axis_tready;
  assign load            = !tvalid_q || m_axis_tready;
  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign event_tlast_err = err_q;

  // IDLE with a full bank reads the first CP sample directly, saving a cycle of latency.
  always_comb begin
    cur_state = state_q;
    cur_idx   = rd_idx_q;
    rd_act    = 1'b1;
    if (state_q == IDLE) begin
      cur_state = CP;
      cur_idx   = CP_START;
      rd_act    = full_q[rd_bank_q];
    end
  end

  ofdm_cp_pingpong_ram #(.NFFT(NFFT), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (s_axis_tdata),
    .raddr ({rd_bank_q, cur_idx}),
    .rdata (rd_data)
  );

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    state_d   = state_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    rdy_d     = 1'b1;
    err_d     = 1'b0;

    if (wr_en) begin
      err_d = s_axis_tlast != (wr_cnt_q == LAST_IDX);
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    if (load) begin
      tvalid_d = rd_act;
      if (rd_act) begin
        tdata_d = rd_data;
        tuser_d = (cur_state == CP) && (cur_idx == CP_START);
        tlast_d = (cur_state == BODY) && (cur_idx == LAST_IDX);
        if (cur_idx != LAST_IDX) begin
          state_d  = cur_state;
          rd_idx_d = cur_idx + AW'(1);
        end else if (cur_state == CP) begin
          state_d  = BODY;
          rd_idx_d = '0;
        end else begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_idx_d          = CP_START;
          state_d           = full_q[~rd_bank_q] ? CP : IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      full_q    <= '0;
      rdy_q     <= 1'b0;
      state_q   <= IDLE;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
      rdy_q     <= rdy_d;
      state_q   <= state_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// tb/tb_ofdm_cp_insert.sv - self-checking bench for ofdm_cp_insert
module tb_ofdm_cp_insert;

  localparam int NF = 64;
  localparam int CPL = 16;

  typedef struct packed {
    logic        u;
    logic        l;
    logic [31:0] d;
  } exp_t;

  logic        clk, rst_n;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast, m_tuser, ev_err;
  logic        rnd_en;

  logic [31:0] s16_tdata, m16_tdata;
  logic        s16_tvalid, s16_tready, s16_tlast;
  logic        m16_tvalid, m16_tready, m16_tlast, m16_tuser, ev16_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] in_buf[$];
  exp_t        exp_q[$];
  int          out_cyc[$];
  int          n_out = 0, err_seen = 0, bp_cycles = 0, cyc = 0;
  int          last_in_cyc = 0, valid_rise_cyc = 0;
  logic        prev_valid = 1'b0;

  ofdm_cp_insert u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .event_tlast_err(ev_err)
  );

  ofdm_cp_insert #(.NFFT(16), .CP_LEN(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s16_tdata), .s_axis_tvalid(s16_tvalid), .s_axis_tready(s16_tready), .s_axis_tlast(s16_tlast),
    .m_axis_tdata(m16_tdata), .m_axis_tvalid(m16_tvalid), .m_axis_tready(m16_tready),
    .m_axis_tlast(m16_tlast), .m_axis_tuser(m16_tuser), .event_tlast_err(ev16_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: every NFFT accepted samples form a symbol; output is its tail then the whole symbol.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_buf.delete();
      exp_q.delete();
      prev_valid <= 1'b0;
    end else begin
      cyc++;
      if (s_tvalid && !s_tready) bp_cycles++;
      if (s_tvalid && s_tready) begin
        last_in_cyc = cyc;
        in_buf.push_back(s_tdata);
        if (in_buf.size() == NF) begin
          for (int k = 0; k < NF + CPL; k++)
            exp_q.push_back('{u: (k == 0), l: (k == NF + CPL - 1),
                              d: in_buf[(k < CPL) ? (NF - CPL + k) : (k - CPL)]});
          in_buf.delete();
        end
      end
      if (ev_err) err_seen++;
      if (m_tvalid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid <= m_tvalid;
      if (m_tvalid) begin
        check("out_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("out_tdata", m_tdata, exp_q[0].d);
          check("out_tuser", m_tuser, exp_q[0].u);
          check("out_tlast", m_tlast, exp_q[0].l);
          if (m_tready) begin
            void'(exp_q.pop_front());
            n_out++;
            out_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    logic hs;
    int   t;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1; t = 0;
    do begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 3000);
    check("push_hs", hs, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_out(input int target, input string tag);
    int t = 0;
    while (n_out < target && t < 6000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, n_out, target);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic send_syms(input int nsym);
    for (int k = 0; k < nsym; k++)
      for (int i = 0; i < NF; i++) push(32'(k * 256 + i), i == NF - 1);
  endtask

  initial begin
    int n0, e0, b0, t, got, idx, e;
    logic hs;
    rst_n = 1'b0; rnd_en = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s16_tdata = '0; s16_tvalid = 1'b0; s16_tlast = 1'b0; m16_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_err", ev_err, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_tvalid", m_tvalid, 0);

    // 1: single ramp symbol
    n0 = n_out; e0 = err_seen;
    for (int i = 0; i < NF; i++) push(32'(i), i == NF - 1);
    wait_out(n0 + 80, "t1_count");
    check("t1_err", err_seen - e0, 0);
    check("t1_latency", valid_rise_cyc - last_in_cyc, 2);

    // 2: back-to-back symbols, gapless output and input back-pressure
    n0 = n_out; e0 = err_seen; b0 = bp_cycles;
    send_syms(4);
    wait_out(n0 + 320, "t2_count");
    check("t2_gapless", out_cyc[n0 + 319] - out_cyc[n0], 319);
    check("t2_backpressure", bp_cycles > b0, 1);
    check("t2_err", err_seen - e0, 0);

    // 3: random downstream stalls
    n0 = n_out; e0 = err_seen;
    rnd_en = 1'b1;
    send_syms(4);
    wait_out(n0 + 320, "t3_count");
    rnd_en = 1'b0;
    check("t3_err", err_seen - e0, 0);

    // 4: misplaced tlast
    n0 = n_out; e0 = err_seen;
    for (int i = 0; i < NF; i++) push(32'(i), i == 40);
    wait_out(n0 + 80, "t4_count");
    check("t4_err", err_seen - e0, 2);

    // 5: reset during CP of symbol 2
    n0 = n_out; t = 0;
    send_syms(3);
    while (n_out < n0 + 165 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("t5_reached_cp", n_out >= n0 + 165, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", m_tvalid, 0);
    check("t5_rst_tdata", m_tdata, 0);
    check("t5_rst_tlast", m_tlast, 0);
    check("t5_rst_tuser", m_tuser, 0);
    check("t5_rst_s_tready", s_tready, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_residual", m_tvalid, 0);
    n0 = n_out; e0 = err_seen;
    for (int i = 0; i < NF; i++) push(32'(i), i == NF - 1);
    wait_out(n0 + 80, "t5_count");
    check("t5_err", err_seen - e0, 0);

    // 6: NFFT=16, CP_LEN=4 instance
    idx = 0; got = 0; t = 0;
    @(posedge clk);
    #1;
    s16_tvalid = 1'b1; s16_tdata = 32'hA000; s16_tlast = 1'b0;
    while (got < 20 && t < 300) begin
      @(negedge clk);
      hs = s16_tvalid && s16_tready;
      if (m16_tvalid) begin
        e = (got < 4) ? 12 + got : got - 4;
        check("t6_tdata", m16_tdata, 32'hA000 + 32'(e));
        check("t6_tlast", m16_tlast, got == 19);
        check("t6_tuser", m16_tuser, got == 0);
        got++;
      end
      @(posedge clk);
      #1;
      if (hs) idx++;
      s16_tvalid = idx < 16;
      s16_tdata  = 32'hA000 + 32'(idx);
      s16_tlast  = idx == 15;
      t++;
    end
    check("t6_count", got, 20);
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle", m16_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
